ntt_buf_ctrl: RTL and testbench

//  Sequencer for one 96x32 coefficient buffer (32 words x 8 coeffs x 12 bit = 256 coeffs) in the NTT unit.

---
 rtl/ntt_buf_ctrl_pkg.sv | 24 ++
 rtl/ntt_wb_delay.sv | 35 +++
 rtl/ntt_buf_ctrl.sv | 141 ++++++++++++++
 tb/tb_ntt_buf_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ntt_buf_ctrl_pkg.sv
// Shared types and constants for the NTT coefficient-buffer sequencer.
// Buffer geometry: 32 words x 8 coeffs x 12 bit.
package ntt_buf_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_UNLOAD = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int NTT_WORDS      = 32;
  localparam int COEF_W         = 12;
  localparam int COEFS_PER_WORD = 8;
  localparam int WORD_W         = COEF_W * COEFS_PER_WORD;

  // Inverse transforms walk the twiddle stages from the top down.
  function automatic logic [2:0] stage_sel(input logic inv, input logic [2:0] stg,
                                           input logic [2:0] last);
    return inv ? 3'(last - stg) : stg;
  endfunction

endpackage

// File: rtl/ntt_wb_delay.sv
// Write-back delay line: carries {valid, addr} of each butterfly read until its
// result returns LAT cycles later.
module ntt_wb_delay #(
  parameter int AW  = 5,
  parameter int LAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic [AW-1:0] in_addr,
  output logic          out_vld,
  output logic [AW-1:0] out_addr
);

  logic [LAT-1:0]         vld_pipe;
  logic [LAT-1:0][AW-1:0] addr_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
    end else begin
      vld_pipe[0]  <= in_vld;
      addr_pipe[0] <= in_addr;
      for (int i = 1; i < LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
    end
  end

  assign out_vld  = vld_pipe[LAT-1];
  assign out_addr = addr_pipe[LAT-1];

endmodule

// File: rtl/ntt_buf_ctrl.sv
// Sequencer for one NTT coefficient buffer: LOAD, NUM_STAGES in-place butterfly
// passes, UNLOAD. Generates buffer control only; never touches coefficient data.
module ntt_buf_ctrl
  import ntt_buf_ctrl_pkg::*;
#(
  parameter int AW         = 5,
  parameter int NUM_STAGES = 7,
  parameter int PIPE_LAT   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          inv,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          buf_wen,
  output logic [AW-1:0] buf_waddr,
  output logic [AW-1:0] buf_raddr,
  output logic          buf_din_sel,
  output logic          bf_valid,
  output logic [2:0]    bf_stage,
  output logic          busy,
  output logic          done
);

  localparam int WORDS     = 2 ** AW;
  localparam int STAGE_CYC = WORDS + PIPE_LAT;
  localparam int CW        = $clog2(STAGE_CYC);
  localparam logic [CW-1:0] LAST_CYC = CW'(STAGE_CYC - 1);
  localparam logic [CW-1:0] RD_END   = CW'(WORDS);
  localparam logic [2:0]    LAST_STG = 3'(NUM_STAGES - 1);

  state_t        state;
  logic          inv_q;
  logic [AW-1:0] ld_cnt;
  logic [AW-1:0] ul_cnt;
  logic [CW-1:0] st_cyc;
  logic [2:0]    stg;

  logic          rd_phase;
  logic [AW-1:0] rd_cnt;
  logic          wb_vld;
  logic [AW-1:0] wb_addr;

  // Reads occupy the first WORDS cycles of a stage; the rest is pipeline drain.
  assign rd_phase = (state == S_RUN) && (st_cyc < RD_END);
  assign rd_cnt   = st_cyc[AW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      inv_q  <= 1'b0;
      ld_cnt <= '0;
      ul_cnt <= '0;
      st_cyc <= '0;
      stg    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_LOAD;
            inv_q <= inv;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            ld_cnt <= ld_cnt + 1'b1;
            if (ld_cnt == '1) state <= S_RUN;
          end
        end
        S_RUN: begin
          if (st_cyc == LAST_CYC) begin
            st_cyc <= '0;
            if (stg == LAST_STG) begin
              stg   <= '0;
              state <= S_UNLOAD;
            end else begin
              stg <= stg + 1'b1;
            end
          end else begin
            st_cyc <= st_cyc + 1'b1;
          end
        end
        S_UNLOAD: begin
          if (out_ready) begin
            ul_cnt <= ul_cnt + 1'b1;
            if (ul_cnt == '1) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  ntt_wb_delay #(
    .AW  (AW),
    .LAT (PIPE_LAT)
  ) u_wb_delay (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (rd_phase),
    .in_addr  (rd_cnt),
    .out_vld  (wb_vld),
    .out_addr (wb_addr)
  );

  // Output decode depends only on registered state (and the handshake inputs),
  // so an asynchronous reset clears every output without waiting for a clock.
  always_comb begin
    in_ready    = (state == S_LOAD);
    out_valid   = (state == S_UNLOAD);
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
    buf_wen     = 1'b0;
    buf_waddr   = '0;
    buf_raddr   = '0;
    buf_din_sel = 1'b0;
    bf_valid    = 1'b0;
    bf_stage    = '0;
    case (state)
      S_LOAD: begin
        buf_wen   = in_valid;
        buf_waddr = ld_cnt;
      end
      S_RUN: begin
        bf_valid    = rd_phase;
        buf_raddr   = rd_phase ? rd_cnt : '0;
        buf_wen     = wb_vld;
        buf_waddr   = wb_addr;
        buf_din_sel = wb_vld;
        bf_stage    = stage_sel(inv_q, stg, LAST_STG);
      end
      S_UNLOAD: buf_raddr = ul_cnt;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ntt_buf_ctrl.sv
// Scoreboard bench for ntt_buf_ctrl: stimulus plans expected buffer events from
// the transform rules; a negedge monitor pops and compares them.
module tb_ntt_buf_ctrl;

  logic       clk = 1'b0, rst = 1'b0, start = 1'b0, inv = 1'b0;
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic       in_ready, out_valid, buf_wen, buf_din_sel, bf_valid, busy, done;
  logic [4:0] buf_waddr, buf_raddr;
  logic [2:0] bf_stage;

  int checks = 0, failures = 0, cyc = 0;
  bit exp_busy = 0, exp_inrdy = 0, exp_ovld = 0;
  int ul_exp = 0;

  typedef struct {int addr; int aux; int cyc;} ev_t;
  ev_t wq[$], rq[$], oq[$];
  int  dq[$];

  ntt_buf_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .inv(inv),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .buf_wen(buf_wen), .buf_waddr(buf_waddr), .buf_raddr(buf_raddr),
    .buf_din_sel(buf_din_sel), .bf_valid(bf_valid), .bf_stage(bf_stage),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string msg);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s", msg);
    end
  endtask

  function automatic logic [25:0] all_outs();
    return {in_ready, out_valid, buf_wen, buf_waddr, buf_raddr, buf_din_sel,
            bf_valid, bf_stage, busy, done, 5'd0};
  endfunction

  // Monitor: compare whatever the DUT presents against the planned events.
  always @(negedge clk) begin
    ev_t e;
    chk(busy == exp_busy, $sformatf("busy cyc=%0d got=%0b exp=%0b", cyc, busy, exp_busy));
    chk(in_ready == exp_inrdy, $sformatf("in_ready cyc=%0d got=%0b exp=%0b", cyc, in_ready, exp_inrdy));
    chk(out_valid == exp_ovld, $sformatf("out_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, exp_ovld));
    if (buf_wen) begin
      if (wq.size() == 0) chk(0, $sformatf("wr unexpected cyc=%0d addr=%0d exp=none", cyc, buf_waddr));
      else begin
        e = wq.pop_front();
        chk(buf_waddr == e.addr && buf_din_sel == e.aux && cyc == e.cyc,
            $sformatf("wr got addr=%0d sel=%0b cyc=%0d exp addr=%0d sel=%0d cyc=%0d",
                      buf_waddr, buf_din_sel, cyc, e.addr, e.aux, e.cyc));
      end
    end
    if (bf_valid) begin
      if (rq.size() == 0) chk(0, $sformatf("rd unexpected cyc=%0d addr=%0d exp=none", cyc, buf_raddr));
      else begin
        e = rq.pop_front();
        chk(buf_raddr == e.addr && bf_stage == e.aux && cyc == e.cyc,
            $sformatf("rd got addr=%0d stage=%0d cyc=%0d exp addr=%0d stage=%0d cyc=%0d",
                      buf_raddr, bf_stage, cyc, e.addr, e.aux, e.cyc));
      end
    end
    if (out_valid && out_ready) begin
      if (oq.size() == 0) chk(0, $sformatf("out unexpected cyc=%0d addr=%0d exp=none", cyc, buf_raddr));
      else begin
        e = oq.pop_front();
        chk(buf_raddr == e.addr && cyc == e.cyc,
            $sformatf("out got addr=%0d cyc=%0d exp addr=%0d cyc=%0d", buf_raddr, cyc, e.addr, e.cyc));
      end
    end else if (out_valid) begin
      chk(buf_raddr == ul_exp, $sformatf("stall raddr cyc=%0d got=%0d exp=%0d", cyc, buf_raddr, ul_exp));
    end
    if (done) begin
      if (dq.size() == 0) chk(0, $sformatf("done unexpected cyc=%0d exp=none", cyc));
      else begin
        int d;
        d = dq.pop_front();
        chk(cyc == d, $sformatf("done cyc got=%0d exp=%0d", cyc, d));
      end
    end
  end

  task automatic do_reset();
    start = 0; in_valid = 0; out_ready = 0;
    exp_busy = 0; exp_inrdy = 0; exp_ovld = 0;
    #1 rst = 1;
    #1 chk(all_outs() == 0, $sformatf("async reset outputs got=%h exp=0", all_outs()));
    wq.delete(); rq.delete(); oq.delete(); dq.delete();
    @(posedge clk); #1;
    rst = 0;
  endtask

  // pat: 0 = in_valid/out_ready always high, 1 = random, 2 = fixed patterns.
  // abort: 0 = none, 1 = reset during LOAD, 2 = reset during RUN stage 3.
  task automatic run_xfer(input bit iv, input int pat, input int abort);
    int cs, k, l, h, n;
    bit v;
    @(posedge clk); #1;
    start = 1; inv = iv;
    in_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
    cs = cyc; exp_busy = 0; exp_inrdy = 0; exp_ovld = 0;
    k = 0;
    while (k < 32) begin
      @(posedge clk); #1;
      if (abort == 1 && cyc - cs == 12) begin do_reset(); return; end
      start = 1'($urandom_range(0, 1)); inv = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      exp_busy = 1; exp_inrdy = 1;
      v = (pat == 0) ? 1'b1 : (pat == 2) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
      in_valid = v;
      if (v) begin wq.push_back(ev_t'{k, 0, cyc}); k++; end
    end
    l = cyc;
    for (int s = 0; s < 7; s++)
      for (int i = 0; i < 32; i++) begin
        rq.push_back(ev_t'{i, iv ? 6 - s : s, l + 1 + s * 36 + i});
        wq.push_back(ev_t'{i, 1, l + 1 + s * 36 + i + 4});
      end
    while (cyc < l + 252) begin
      @(posedge clk); #1;
      if (abort == 2 && cyc == l + 1 + 3 * 36 + 10) begin do_reset(); return; end
      start = 1'($urandom_range(0, 1)); inv = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
      exp_inrdy = 0;
    end
    k = 0; n = 0;
    while (k < 32) begin
      @(posedge clk); #1;
      start = 1'($urandom_range(0, 1)); inv = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      exp_ovld = 1; ul_exp = k;
      v = (pat == 0) ? 1'b1 : (pat == 2) ? (n % 3 == 0) : 1'($urandom_range(0, 1));
      n++;
      out_ready = v;
      if (v) begin oq.push_back(ev_t'{k, 0, cyc}); k++; end
    end
    h = cyc;
    dq.push_back(pat == 0 ? cs + 317 : h + 1);
    @(posedge clk); #1;
    exp_ovld = 0;
    start = 1'($urandom_range(0, 1)); inv = 1'($urandom_range(0, 1));
    in_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    exp_busy = 0; start = 0;
    @(posedge clk); #1;
    chk(wq.size() == 0 && rq.size() == 0 && oq.size() == 0 && dq.size() == 0,
        $sformatf("drain leftover wr=%0d rd=%0d out=%0d done=%0d exp all 0",
                  wq.size(), rq.size(), oq.size(), dq.size()));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d exp completion", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1;
    @(posedge clk); @(posedge clk); #1;
    chk(all_outs() == 0, $sformatf("reset outputs got=%h exp=0", all_outs()));
    rst = 0;
    run_xfer(0, 0, 0);
    run_xfer(0, 2, 0);
    run_xfer(1, 1, 0);
    run_xfer(1, 1, 1);
    run_xfer(0, 1, 2);
    run_xfer(1, 0, 0);
    run_xfer(1, 2, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
